can_tx_scheduler: RTL

- Holds NUM_MB transmit mailboxes (11-bit ID + 32-bit payload) loaded by the host.
- Picks the pending mailbox with the lowest ID, using CAN priority, and hands it to the CAN frame engine through a start/busy/done handshake.
- Handles the engine's outcome per attempt:
  - arbitration loss → re-queues the mailbox;
  - ACK error → bounded retry;
  - success → reported back to the host.
- Sits between host/FIFO logic and the frame engine; it sequences that single shared datapath.

---
 rtl/can_pkg.sv | 19 +
 rtl/can_prio_select.sv | 29 ++
 rtl/can_tx_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN transmit scheduler.
package can_pkg;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT,
    RESOLVE
  } sched_state_t;

  localparam logic [1:0] RES_OK       = 2'b00;
  localparam logic [1:0] RES_ARB_LOST = 2'b01;
  localparam logic [1:0] RES_ACK_ERR  = 2'b10;

endpackage

// File: rtl/can_prio_select.sv
// Combinational minimum-ID finder; a strict less-than keeps the lowest index on ties.
module can_prio_select
  import can_pkg::*;
#(
  parameter int NUM_MB = 4,
  parameter int IDXW   = $clog2(NUM_MB)
) (
  input  logic [NUM_MB-1:0]                req,
  input  logic [NUM_MB-1:0][CAN_ID_W-1:0]  ids,
  output logic                             valid,
  output logic [IDXW-1:0]                  win_idx
);

  logic [CAN_ID_W-1:0] best_id;

  always_comb begin
    valid   = 1'b0;
    win_idx = '0;
    best_id = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (req[i] && (!valid || (ids[i] < best_id))) begin
        valid   = 1'b1;
        win_idx = IDXW'(i);
        best_id = ids[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Mailbox store plus the FSM that feeds the lowest-ID pending frame to the CAN frame engine.
// Engine handshake: frame_start is held until frame_busy is sampled high; frame_done then ends the attempt.
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int NUM_MB    = 4,
  parameter int IDXW      = $clog2(NUM_MB),
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  mb_wr_en,
  input  logic [IDXW-1:0]       mb_wr_idx,
  input  logic [CAN_ID_W-1:0]   mb_wr_id,
  input  logic [CAN_DATA_W-1:0] mb_wr_data,
  input  logic [NUM_MB-1:0]     mb_abort,
  output logic                  frame_start,
  output logic [CAN_ID_W-1:0]   frame_id,
  output logic [CAN_DATA_W-1:0] frame_data,
  input  logic                  frame_busy,
  input  logic                  frame_done,
  input  logic [1:0]            frame_result,
  output logic [NUM_MB-1:0]     pending,
  output logic                  tx_ok,
  output logic                  tx_fail,
  output logic [IDXW-1:0]       tx_idx
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  sched_state_t                           state_q, state_d;
  logic [NUM_MB-1:0]                      pending_q, pending_d;
  logic [NUM_MB-1:0][RW-1:0]              retry_q, retry_d;
  logic [NUM_MB-1:0][CAN_ID_W-1:0]        mb_id_q, mb_id_d;
  logic [NUM_MB-1:0][CAN_DATA_W-1:0]      mb_data_q, mb_data_d;
  logic [IDXW-1:0]                        sel_idx_q, sel_idx_d;
  logic                                   frame_start_q, frame_start_d;
  logic [CAN_ID_W-1:0]                    frame_id_q, frame_id_d;
  logic [CAN_DATA_W-1:0]                  frame_data_q, frame_data_d;
  logic [1:0]                             result_q, result_d;

  logic                                   active;
  logic                                   win_valid;
  logic [IDXW-1:0]                        win_idx;
  logic                                   tx_ok_c, tx_fail_c;

  // Aborts raised in the SELECT cycle already remove a mailbox from the race.
  can_prio_select #(.NUM_MB(NUM_MB), .IDXW(IDXW)) u_prio (
    .req     (pending_q & ~mb_abort),
    .ids     (mb_id_q),
    .valid   (win_valid),
    .win_idx (win_idx)
  );

  assign active = (state_q == START) || (state_q == WAIT) || (state_q == RESOLVE);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    retry_d       = retry_q;
    mb_id_d       = mb_id_q;
    mb_data_d     = mb_data_q;
    sel_idx_d     = sel_idx_q;
    frame_start_d = frame_start_q;
    frame_id_d    = frame_id_q;
    frame_data_d  = frame_data_q;
    result_d      = result_q;
    tx_ok_c       = 1'b0;
    tx_fail_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|pending_q) state_d = SELECT;
      end
      SELECT: begin
        if (win_valid) begin
          sel_idx_d     = win_idx;
          frame_id_d    = mb_id_q[win_idx];
          frame_data_d  = mb_data_q[win_idx];
          frame_start_d = 1'b1;
          state_d       = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (frame_busy) begin
          frame_start_d = 1'b0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (frame_done) begin
          result_d = frame_result;
          state_d  = RESOLVE;
        end
      end
      RESOLVE: begin
        state_d = IDLE;
        if (result_q == RES_OK) begin
          pending_d[sel_idx_q] = 1'b0;
          tx_ok_c              = 1'b1;
        end else if (result_q != RES_ARB_LOST) begin
          // 2'b11 falls here too: any non-ok, non-arbitration result is an ACK error.
          if (retry_q[sel_idx_q] == RW'(MAX_RETRY)) begin
            pending_d[sel_idx_q] = 1'b0;
            retry_d[sel_idx_q]   = '0;
            tx_fail_c            = 1'b1;
          end else begin
            retry_d[sel_idx_q] = retry_q[sel_idx_q] + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Host side; the mailbox on the engine is frozen, and a write beats an abort.
    for (int i = 0; i < NUM_MB; i++) begin
      if (mb_abort[i] && !(active && (sel_idx_q == IDXW'(i)))) pending_d[i] = 1'b0;
    end
    if (mb_wr_en && !(active && (mb_wr_idx == sel_idx_q))) begin
      pending_d[mb_wr_idx] = 1'b1;
      retry_d[mb_wr_idx]   = '0;
      mb_id_d[mb_wr_idx]   = mb_wr_id;
      mb_data_d[mb_wr_idx] = mb_wr_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      retry_q       <= '0;
      mb_id_q       <= '0;
      mb_data_q     <= '0;
      sel_idx_q     <= '0;
      frame_start_q <= 1'b0;
      frame_id_q    <= '0;
      frame_data_q  <= '0;
      result_q      <= RES_OK;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      retry_q       <= retry_d;
      mb_id_q       <= mb_id_d;
      mb_data_q     <= mb_data_d;
      sel_idx_q     <= sel_idx_d;
      frame_start_q <= frame_start_d;
      frame_id_q    <= frame_id_d;
      frame_data_q  <= frame_data_d;
      result_q      <= result_d;
    end
  end

  assign frame_start = frame_start_q;
  assign frame_id    = frame_id_q;
  assign frame_data  = frame_data_q;
  assign pending     = pending_q;
  assign tx_ok       = tx_ok_c;
  assign tx_fail     = tx_fail_c;
  assign tx_idx      = sel_idx_q;

endmodule
